// File: rtl/entry_pkg.sv
// rtl/entry_pkg.sv - shared types for the decimal digit entry path
package entry_pkg;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;
endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - one-register rising-edge detector for a synchronous level
module rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic sig,
  output logic rise
);
  logic prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= 1'b0;
    else          prev <= sig;
  end

  assign rise = sig & ~prev;
endmodule

// File: rtl/bcd_entry_to_bin.sv
// rtl/bcd_entry_to_bin.sv - keyed BCD digit entry with iterative decimal-to-binary conversion
module bcd_entry_to_bin
  import entry_pkg::*;
#(
  parameter int N_DIGITS = 2,
  parameter int W        = $clog2(10**N_DIGITS)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [3:0]   digit_in,
  input  logic         digit_stb,
  input  logic         convert,
  input  logic         clear,
  output bcd_t         bcd_digits [N_DIGITS-1:0],
  output logic [W-1:0] bin_out,
  output logic         bin_valid,
  output logic         busy,
  output logic         err
);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  state_t         state_q, state_d;
  logic           dig_rise, conv_rise, digit_ok;
  logic [W-1:0]   acc_q, acc_next;
  logic [IW-1:0]  idx_q;

  rise_detect u_stb_rise  (.clk(clk), .reset_n(reset_n), .sig(digit_stb), .rise(dig_rise));
  rise_detect u_conv_rise (.clk(clk), .reset_n(reset_n), .sig(convert),   .rise(conv_rise));

  assign digit_ok = (digit_in <= BCD_MAX);
  assign acc_next = (acc_q << 3) + (acc_q << 1) + W'(bcd_digits[idx_q]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // A digit edge always shadows a coincident convert edge, even an invalid digit.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (!dig_rise && conv_rise) state_d = CONV;
        CONV:    if (idx_q == '0) state_d = DONE;
        DONE: begin
          if (dig_rise) begin
            if (digit_ok) state_d = IDLE;
          end else if (conv_rise) begin
            state_d = CONV;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q == CONV);
    bin_valid = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_DIGITS; i++) bcd_digits[i] <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      bin_out <= '0;
      err     <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < N_DIGITS; i++) bcd_digits[i] <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      bin_out <= '0;
      err     <= 1'b0;
    end else if (state_q == CONV) begin
      acc_q <= acc_next;
      idx_q <= idx_q - IW'(1);
      if (idx_q == '0) bin_out <= acc_next;
    end else if (dig_rise) begin
      if (digit_ok) begin
        // Keying after a finished conversion starts a fresh number.
        for (int i = 1; i < N_DIGITS; i++)
          bcd_digits[i] <= (state_q == DONE) ? '0 : bcd_digits[i-1];
        bcd_digits[0] <= digit_in;
      end else begin
        err <= 1'b1;
      end
    end else if (conv_rise) begin
      acc_q <= '0;
      idx_q <= IW'(N_DIGITS - 1);
    end
  end
endmodule

// File: tb/tb_bcd_entry_to_bin.sv
// tb/tb_bcd_entry_to_bin.sv - directed bench with decimal-value reference model
module tb_bcd_entry_to_bin;
  localparam int N = 2;
  localparam int W = 7;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   digit_in;
  logic         digit_stb, convert, clear;
  logic [3:0]   bcd_digits [N-1:0];
  logic [W-1:0] bin_out;
  logic         bin_valid, busy, err;

  int tests = 0;
  int fails = 0;

  bcd_entry_to_bin #(.N_DIGITS(N), .W(W)) dut (
    .clk(clk), .reset_n(reset_n), .digit_in(digit_in), .digit_stb(digit_stb),
    .convert(convert), .clear(clear), .bcd_digits(bcd_digits), .bin_out(bin_out),
    .bin_valid(bin_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: digits as decimal places, a countdown of conversion cycles left.
  int m_dig [N];
  int m_val, m_left;
  bit m_valid, m_err, p_stb, p_conv;

  function automatic int decimal_value();
    int v = 0;
    for (int i = 0; i < N; i++) v += m_dig[i] * (10 ** i);
    return v;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit ds, cs;
    if (!reset_n) begin
      for (int i = 0; i < N; i++) m_dig[i] = 0;
      m_val = 0; m_left = 0; m_valid = 0; m_err = 0; p_stb = 0; p_conv = 0;
    end else begin
      ds = digit_stb && !p_stb;
      cs = convert && !p_conv;
      p_stb = digit_stb;
      p_conv = convert;
      if (clear) begin
        for (int i = 0; i < N; i++) m_dig[i] = 0;
        m_val = 0; m_left = 0; m_valid = 0; m_err = 0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_val = decimal_value();
          m_valid = 1;
        end
      end else if (ds) begin
        if (digit_in > 9) m_err = 1;
        else begin
          for (int i = N - 1; i > 0; i--) m_dig[i] = m_valid ? 0 : m_dig[i-1];
          m_dig[0] = int'(digit_in);
          m_valid = 0;
        end
      end else if (cs) begin
        m_valid = 0;
        m_left = N;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_dig1",  int'(bcd_digits[1]), m_dig[1]);
    chk("cyc_dig0",  int'(bcd_digits[0]), m_dig[0]);
    chk("cyc_bin",   int'(bin_out), m_val);
    chk("cyc_valid", int'(bin_valid), int'(m_valid));
    chk("cyc_busy",  int'(busy), int'(m_left > 0));
    chk("cyc_err",   int'(err), int'(m_err));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key(input int d);
    digit_in = 4'(d);
    digit_stb = 1'b1;
    tick(1);
    digit_stb = 1'b0;
    tick(1);
  endtask

  task automatic conv_go();
    convert = 1'b1;
    tick(1);
    convert = 1'b0;
  endtask

  task automatic digits_are(input string name, input int d1, input int d0);
    chk({name, "_d1"}, int'(bcd_digits[1]), d1);
    chk({name, "_d0"}, int'(bcd_digits[0]), d0);
  endtask

  // Convert edge was just seen; busy for two cycles, then valid with the result.
  task automatic expect_conv(input string name, input int v);
    chk({name, "_busy1"}, int'(busy), 1);
    tick(1);
    chk({name, "_busy2"}, int'(busy), 1);
    chk({name, "_nv"}, int'(bin_valid), 0);
    tick(1);
    chk({name, "_busy_off"}, int'(busy), 0);
    chk({name, "_valid"}, int'(bin_valid), 1);
    chk({name, "_bin"}, int'(bin_out), v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; digit_in = '0; digit_stb = 0; convert = 0; clear = 0;
    tick(2);
    digits_are("rst", 0, 0);
    chk("rst_bin", int'(bin_out), 0);
    chk("rst_valid", int'(bin_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    reset_n = 1'b1;
    tick(1);

    key(4); key(7);
    digits_are("k47", 4, 7);
    conv_go();
    expect_conv("c47", 47);
    tick(2);
    chk("c47_hold", int'(bin_out), 47);

    key(8);
    chk("k8_valid_drop", int'(bin_valid), 0);
    digits_are("k8", 0, 8);
    conv_go();
    expect_conv("c8", 8);

    key(9); key(9);
    conv_go();
    expect_conv("c99", 99);
    key(1); key(2); key(3);
    digits_are("k123", 2, 3);
    conv_go();
    expect_conv("c23", 23);

    clear = 1'b1; tick(1); clear = 1'b0;
    key(12);
    chk("bad_err", int'(err), 1);
    digits_are("bad", 0, 0);
    key(5);
    conv_go();
    expect_conv("c5", 5);
    chk("err_sticky", int'(err), 1);
    clear = 1'b1; tick(1); clear = 1'b0;
    chk("err_clr", int'(err), 0);
    chk("clr_bin", int'(bin_out), 0);

    digit_in = 4'd3; digit_stb = 1'b1;
    tick(10);
    digit_stb = 1'b0;
    tick(1);
    digits_are("held", 0, 3);

    key(4);
    conv_go();
    clear = 1'b1; tick(1); clear = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_bin", int'(bin_out), 0);
    tick(3);
    chk("abort_nv", int'(bin_valid), 0);
    digits_are("abort", 0, 0);

    digit_in = 4'd1; digit_stb = 1'b1; convert = 1'b1;
    tick(1);
    digit_stb = 1'b0; convert = 1'b0;
    chk("both_busy", int'(busy), 0);
    digits_are("both", 0, 1);
    tick(3);
    chk("both_nv", int'(bin_valid), 0);

    key(4); key(7);
    conv_go();
    #3 reset_n = 1'b0;
    #1;
    digits_are("arst", 0, 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_valid", int'(bin_valid), 0);
    chk("arst_bin", int'(bin_out), 0);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    chk("arst_stay_idle", int'(bin_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
